// File: rtl/popgen_pkg.sv
// Shared types and mask helpers for the popcount pattern generator.
// Configuration macro used by the top: POPGEN_INDEX_EN (adds out_index port).
package popgen_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    localparam int MAX_W = 32;

    // Lowest k bits set, clipped to width: the first (smallest) k-ones pattern.
    function automatic logic [MAX_W-1:0] low_mask(input int k, input int width);
        logic [MAX_W-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_W; i++) begin
            if (i < k && i < width) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

    // Highest k bits of a width-bit word set: the last (largest) k-ones pattern.
    function automatic logic [MAX_W-1:0] high_mask(input int k, input int width);
        logic [MAX_W-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_W; i++) begin
            if (i < width && i >= width - k) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/popgen_next.sv
// Combinational Gosper step: given a word x, produce the next larger word with
// the same number of ones. Only meaningful for x != 0 and x not already the
// highest pattern; the caller stops on the last pattern.
module popgen_next
    import popgen_pkg::*;
#(
    parameter int WIDTH = 3
) (
    input  logic [WIDTH-1:0] i_x,
    output logic [WIDTH-1:0] o_next
);

    localparam int CTZW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    logic [WIDTH-1:0] w_lowbit;
    logic [WIDTH-1:0] w_ripple;
    logic [WIDTH-1:0] w_changed;
    logic [CTZW-1:0]  w_ctz;

    assign w_lowbit  = i_x & (~i_x + WIDTH'(1));
    assign w_ripple  = i_x + w_lowbit;
    assign w_changed = i_x ^ w_ripple;

    // Trailing-zero count: scan from the top so the lowest set bit wins.
    always_comb begin
        w_ctz = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (i_x[i]) begin
                w_ctz = CTZW'(i);
            end
        end
    end

    assign o_next = w_ripple | ((w_changed >> 2) >> w_ctz);

endmodule

// File: rtl/popcount_pattern_gen.sv
// Streams every WIDTH-bit word with exactly k ones, in ascending order, one
// word per accepted output beat. Requests with k > WIDTH pulse err instead.
// Optional feature macro: POPGEN_INDEX_EN adds out_index (beat number).
module popcount_pattern_gen
    import popgen_pkg::*;
#(
    parameter int WIDTH = 3,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [CW-1:0]    req_count,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_word,
    output logic             out_last,
    output logic             err
`ifdef POPGEN_INDEX_EN
    ,
    output logic [WIDTH-1:0] out_index
`endif
);

    localparam logic [CW:0] WIDTH_C = (CW + 1)'(WIDTH);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CW-1:0]    r_k;
    logic [WIDTH-1:0] r_word;
    logic             r_last;
    logic             r_err;

    logic             w_accept;
    logic             w_k_bad;
    logic             w_fire;
    logic [WIDTH-1:0] w_first;
    logic [WIDTH-1:0] w_first_hi;
    logic [WIDTH-1:0] w_hi;
    logic [WIDTH-1:0] w_next;

    assign req_ready = (r_state == IDLE);
    assign out_valid = (r_state == EMIT);
    assign out_word  = r_word;
    assign out_last  = r_last;
    assign err       = r_err;

    assign w_accept   = req_valid && req_ready;
    assign w_k_bad    = {1'b0, req_count} > WIDTH_C;
    assign w_fire     = out_valid && out_ready;
    assign w_first    = WIDTH'(low_mask(int'(req_count), WIDTH));
    assign w_first_hi = WIDTH'(high_mask(int'(req_count), WIDTH));
    assign w_hi       = WIDTH'(high_mask(int'(r_k), WIDTH));

    popgen_next #(
        .WIDTH (WIDTH)
    ) u_next (
        .i_x    (r_word),
        .o_next (w_next)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: start on a valid request, return to idle after the last beat.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept && !w_k_bad) begin
                    w_state_nxt = EMIT;
                end
            end
            EMIT: begin
                if (w_fire && r_last) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Pattern datapath: load first pattern on accept, advance on each transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_k    <= '0;
            r_word <= '0;
            r_last <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_err <= w_accept && w_k_bad;
            if (w_accept && !w_k_bad) begin
                r_k    <= req_count;
                r_word <= w_first;
                r_last <= (w_first == w_first_hi);
            end else if (w_fire) begin
                if (r_last) begin
                    r_word <= '0;
                    r_last <= 1'b0;
                end else begin
                    r_word <= w_next;
                    r_last <= (w_next == w_hi);
                end
            end
        end
    end

`ifdef POPGEN_INDEX_EN
    logic [WIDTH-1:0] r_index;

    assign out_index = r_index;

    // Beat counter: zero at the first beat, cleared again once the stream ends.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_index <= '0;
        end else if (w_accept) begin
            r_index <= '0;
        end else if (w_fire) begin
            if (r_last) begin
                r_index <= '0;
            end else begin
                r_index <= r_index + WIDTH'(1);
            end
        end
    end
`endif

endmodule
